// File: rtl/fifo_flags_if.sv
// Handshake/status bundle for fifo_flags. The slave modport is the FIFO side.
// FIFO_HWM_EN adds the high-water-mark output hwm.
interface fifo_flags_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              push;
    logic [WIDTH-1:0]  data_i;
    logic              full;
    logic              pop;
    logic [WIDTH-1:0]  data_o;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   af_thresh;
    logic [ADDR_W:0]   ae_thresh;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;
    logic              clr_err;
`ifdef FIFO_HWM_EN
    logic [ADDR_W:0]   hwm;
`endif

    modport slave (
        input  push, data_i, pop, af_thresh, ae_thresh, clr_err,
        output full, data_o, empty, count, almost_full, almost_empty, overflow, underflow
`ifdef FIFO_HWM_EN
        , output hwm
`endif
    );

    modport master (
        output push, data_i, pop, af_thresh, ae_thresh, clr_err,
        input  full, data_o, empty, count, almost_full, almost_empty, overflow, underflow
`ifdef FIFO_HWM_EN
        , input hwm
`endif
    );
endinterface

// File: rtl/fifo_flags.sv
// Synchronous FIFO with occupancy count, programmable almost flags, sticky errors
// and registered or FWFT read port. Define FIFO_HWM_EN to add the hwm output.
module fifo_flags #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int FWFT  = 0
) (
    input logic         clk,
    input logic         rst,
    fifo_flags_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr, rd_ptr, count, next_count;
    logic             full, empty, wr_en, rd_en;
    logic             overflow, underflow;

    // Extra wrap bit distinguishes full from empty when the low bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign wr_en = bus.push & ~full;
    assign rd_en = bus.pop & ~empty;

    always_comb begin
        next_count = count;
        if (wr_en && !rd_en)
            next_count = count + CNT_ONE;
        else if (rd_en && !wr_en)
            next_count = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + CNT_ONE;
            if (rd_en) rd_ptr <= rd_ptr + CNT_ONE;
            count <= next_count;
            // A new error outranks a coincident clear.
            if (bus.push && full)  overflow <= 1'b1;
            else if (bus.clr_err)  overflow <= 1'b0;
            if (bus.pop && empty)  underflow <= 1'b1;
            else if (bus.clr_err)  underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[wr_ptr[ADDR_W-1:0]] <= bus.data_i;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_o = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
        end else begin : g_reg
            logic [WIDTH-1:0] data_q;
            always_ff @(posedge clk) begin
                if (rst)
                    data_q <= '0;
                else if (rd_en)
                    data_q <= mem[rd_ptr[ADDR_W-1:0]];
            end
            assign bus.data_o = data_q;
        end
    endgenerate

`ifdef FIFO_HWM_EN
    logic [ADDR_W:0] hwm_q;
    always_ff @(posedge clk) begin
        if (rst)
            hwm_q <= '0;
        else if (bus.clr_err)
            hwm_q <= count;
        else if (next_count > hwm_q)
            hwm_q <= next_count;
    end
    assign bus.hwm = hwm_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = count;
    assign bus.almost_full  = (count >= bus.af_thresh);
    assign bus.almost_empty = (count <= bus.ae_thresh);
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule
